// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO and a runtime-loadable bit period.
// Frames go out LSB-first; the serial line is registered and idles high.
module uart_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic        i_Clock,
  input  logic        rst_n,
  input  logic [31:0] CLKS_PER_BIT,
  input  logic        ld_CLKS_PER_BIT,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  output logic        o_Tx_Full,
  output logic        o_Tx_Empty,
  output logic        o_Tx_Active,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Done
);

  localparam int unsigned CntW = FIFO_AW + 1;
  localparam logic [FIFO_AW:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
    StCleanup = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        clks_per_bit_q;
  logic [31:0]        n_bits;
  logic               bit_last;
  logic [31:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               tx_done;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               push, pop;

  // A programmed period of zero behaves as one clock per bit.
  assign n_bits   = (clks_per_bit_q == 32'd0) ? 32'd1 : clks_per_bit_q;
  assign bit_last = (clk_cnt_q == n_bits - 32'd1);

  assign o_Tx_Full   = (count_q == FullCnt);
  assign o_Tx_Empty  = (count_q == '0);
  assign o_Tx_Active = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = tx_done;

  // Fullness uses the count before any same-cycle pop.
  assign push = i_Tx_DV && !o_Tx_Full;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      clks_per_bit_q <= 32'd0;
    end else if (ld_CLKS_PER_BIT && !o_Tx_Active) begin
      clks_per_bit_q <= CLKS_PER_BIT;
    end
  end

  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= 32'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_done   = 1'b0;
    serial_d  = 1'b1;

    case (state_q)
      StIdle: begin
        if (!o_Tx_Empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          clk_cnt_d = 32'd0;
          bit_idx_d = 3'd0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_last) begin
          clk_cnt_d = 32'd0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      StData: begin
        if (bit_last) begin
          clk_cnt_d = 32'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      StStop: begin
        if (bit_last) begin
          tx_done   = 1'b1;
          clk_cnt_d = 32'd0;
          state_d   = StCleanup;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      StCleanup: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Line level follows the next state so it changes on the same edge as the state.
    case (state_d)
      StStart: serial_d = 1'b0;
      StData:  serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: writes queue expected bytes, and a line
// monitor decodes every frame and checks bit timing, flags and Done against them.
module tb_uart_tx;

  localparam int unsigned Depth = 4;

  logic        i_Clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] CLKS_PER_BIT = 32'd0;
  logic        ld_CLKS_PER_BIT = 1'b0;
  logic        i_Tx_DV = 1'b0;
  logic [7:0]  i_Tx_Byte = 8'd0;
  logic        o_Tx_Full, o_Tx_Empty, o_Tx_Active, o_Tx_Serial, o_Tx_Done;

  uart_tx #(
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) dut (
    .i_Clock        (i_Clock),
    .rst_n          (rst_n),
    .CLKS_PER_BIT   (CLKS_PER_BIT),
    .ld_CLKS_PER_BIT(ld_CLKS_PER_BIT),
    .i_Tx_DV        (i_Tx_DV),
    .i_Tx_Byte      (i_Tx_Byte),
    .o_Tx_Full      (o_Tx_Full),
    .o_Tx_Empty     (o_Tx_Empty),
    .o_Tx_Active    (o_Tx_Active),
    .o_Tx_Serial    (o_Tx_Serial),
    .o_Tx_Done      (o_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bytes accepted but not yet started, and the effective baud.
  logic [7:0]  exp_q[$];
  int unsigned cpb_model = 0;

  // Monitor view of the line.
  bit          mon_in_frame = 1'b0;
  bit          cur_active   = 1'b0;
  int          mon_bit      = 0;
  int unsigned mon_cnt      = 0;
  int unsigned mon_n        = 1;
  logic [7:0]  mon_byte     = 8'd0;
  logic [7:0]  mon_rx       = 8'd0;
  int          idle_run     = 0;
  bit          b2b          = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic exp_bit;
    forever begin
      @(negedge i_Clock);
      if (!rst_n) begin
        mon_in_frame = 1'b0;
        cur_active   = 1'b0;
        idle_run     = 0;
        b2b          = 1'b0;
      end else begin
        cur_active = mon_in_frame;
        if (!mon_in_frame) begin
          if (o_Tx_Serial === 1'b0) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_start: got start bit, expected idle line at %0t", $time);
              mon_byte = 8'd0;
            end else begin
              mon_byte = exp_q.pop_front();
            end
            if (b2b) check("interframe_gap", 32'(idle_run), 32'd2);
            mon_n        = (cpb_model == 0) ? 1 : cpb_model;
            mon_in_frame = 1'b1;
            cur_active   = 1'b1;
            mon_bit      = 0;
            mon_cnt      = 0;
            mon_rx       = 8'd0;
          end else begin
            check("idle_done", 32'(o_Tx_Done), 32'd0);
            check("idle_active", 32'(o_Tx_Active), 32'd0);
            idle_run++;
          end
        end
        if (mon_in_frame) begin
          if (mon_bit == 0)      exp_bit = 1'b0;
          else if (mon_bit == 9) exp_bit = 1'b1;
          else                   exp_bit = mon_byte[mon_bit-1];
          check("line_bit", 32'(o_Tx_Serial), 32'(exp_bit));
          check("frame_active", 32'(o_Tx_Active), 32'd1);
          check("frame_done", 32'(o_Tx_Done), 32'(mon_bit == 9 && mon_cnt == mon_n - 1));
          if (mon_bit >= 1 && mon_bit <= 8 && mon_cnt == 0) mon_rx[mon_bit-1] = o_Tx_Serial;
          mon_cnt++;
          if (mon_cnt == mon_n) begin
            mon_cnt = 0;
            mon_bit++;
            if (mon_bit == 10) begin
              mon_in_frame = 1'b0;
              check("rx_byte", 32'(mon_rx), 32'(mon_byte));
              idle_run = 0;
              b2b      = (exp_q.size() > 0);
            end
          end
        end
        check("full_flag", 32'(o_Tx_Full), 32'(exp_q.size() == Depth));
        check("empty_flag", 32'(o_Tx_Empty), 32'(exp_q.size() == 0));
      end
    end
  end

  task automatic tick();
    @(negedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = b;
    if (exp_q.size() < Depth) exp_q.push_back(b);
    tick();
    i_Tx_DV = 1'b0;
  endtask

  task automatic load_baud(input int unsigned v);
    CLKS_PER_BIT    = v;
    ld_CLKS_PER_BIT = 1'b1;
    if (!cur_active) cpb_model = v;
    tick();
    ld_CLKS_PER_BIT = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mon_in_frame) break;
      tick();
    end
    check("drain_done", 32'(exp_q.size() == 0 && !mon_in_frame), 32'd1);
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("rst_serial", 32'(o_Tx_Serial), 32'd1);
    check("rst_empty", 32'(o_Tx_Empty), 32'd1);
    check("rst_full", 32'(o_Tx_Full), 32'd0);
    check("rst_active", 32'(o_Tx_Active), 32'd0);
    check("rst_done", 32'(o_Tx_Done), 32'd0);
    rst_n = 1'b1;
    idle(50);

    // Single frame, start bit two cycles after the write.
    load_baud(4);
    write_byte(8'hA5);
    check("lat_line_high", 32'(o_Tx_Serial), 32'd1);
    check("lat_not_empty", 32'(o_Tx_Empty), 32'd0);
    tick();
    check("lat_start_low", 32'(o_Tx_Serial), 32'd0);
    drain(200);

    // Burst of six: five accepted, last dropped.
    for (int i = 1; i <= 6; i++) write_byte(8'(i));
    check("full_after_burst", 32'(o_Tx_Full), 32'd1);
    drain(600);

    // Baud load ignored mid-frame, honoured when idle.
    write_byte(8'h5A);
    idle(12);
    load_baud(8);
    drain(200);
    write_byte(8'hC3);
    drain(200);
    load_baud(8);
    write_byte(8'h96);
    drain(300);

    // Degenerate periods 0 and 1.
    load_baud(0);
    write_byte(8'hFF);
    drain(100);
    load_baud(1);
    write_byte(8'hFF);
    write_byte(8'hFF);
    drain(100);

    // Reset during data bit 3 with bytes queued.
    load_baud(4);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    for (int i = 0; i < 300; i++) begin
      if (mon_in_frame && mon_bit == 4) break;
      tick();
    end
    check("reached_bit3", 32'(mon_in_frame && mon_bit == 4), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    cpb_model = 0;
    #1;
    check("arst_serial", 32'(o_Tx_Serial), 32'd1);
    check("arst_empty", 32'(o_Tx_Empty), 32'd1);
    check("arst_active", 32'(o_Tx_Active), 32'd0);
    check("arst_done", 32'(o_Tx_Done), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(60);
    load_baud(4);
    write_byte(8'h3C);
    drain(200);

    // Random traffic with occasional (possibly locked-out) baud reloads.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) load_baud($urandom_range(0, 5));
      repeat ($urandom_range(1, 3)) write_byte(8'($urandom));
      idle($urandom_range(0, 40));
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the MCU's UART receiver. Shares its runtime-loadable CLKS_PER_BIT baud interface.
- Accepts bytes from the bus-side register interface into a small TX FIFO.
- Serialises each byte LSB-first as 1 start bit (0), 8 data bits, 1 stop bit (1), each bit lasting CLKS_PER_BIT_s clocks.
- Flags FIFO-full, line activity and per-frame completion.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- FIFO_AW, 2, FIFO pointer width = log2(FIFO_DEPTH).

Ports:
- i_Clock  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- CLKS_PER_BIT  input  32  clocks per serial bit, candidate value
- ld_CLKS_PER_BIT  input  1  load CLKS_PER_BIT into internal CLKS_PER_BIT_s
- i_Tx_DV  input  1  one-cycle write strobe for i_Tx_Byte
- i_Tx_Byte  input  8  byte to transmit
- o_Tx_Full  output  1  FIFO holds FIFO_DEPTH entries; writes are dropped
- o_Tx_Empty  output  1  FIFO holds 0 entries
- o_Tx_Active  output  1  frame in progress (states START, DATA, STOP)
- o_Tx_Serial  output  1  serial line, registered, idle high
- o_Tx_Done  output  1  one-cycle pulse when a stop bit completes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - CLKS_PER_BIT_s=0; FIFO pointers and count=0; all counters=0; shift register=0.
  - State=IDLE; o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Tx_Full=0; o_Tx_Empty=1.
  - Reset mid-frame aborts the frame immediately: the line returns high asynchronously and FIFO contents are discarded.
- Baud register:
  - CLKS_PER_BIT_s <= CLKS_PER_BIT when ld_CLKS_PER_BIT=1 and o_Tx_Active=0; the load is ignored while a frame is active.
  - Effective bit length N = max(CLKS_PER_BIT_s, 1).
- FIFO:
  - A write is accepted when i_Tx_DV=1 and count<FIFO_DEPTH, with count sampled before any same-cycle pop. There is no write-through bypass.
  - A write while full is silently dropped; FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous write and pop leaves count unchanged.
  - o_Tx_Full and o_Tx_Empty are decoded from the registered count.
- State machine (ps/ns, Moore line output registered alongside ps):
  - IDLE: line=1. If the FIFO is not empty, pop the head into the 8-bit shift register, clear the bit counter and bit index, and go to START. Otherwise stay in IDLE.
  - START: line=0 for N cycles (counter 0..N-1). At count N-1: clear the counter and go to DATA.
  - DATA: line=shift[0] for N cycles. At count N-1: shift right and clear the counter. If bit index <7, increment the index and stay in DATA. If index=7, clear the index and go to STOP.
  - STOP: line=1 for N cycles. At count N-1: pulse o_Tx_Done for exactly that cycle, clear the counter and go to CLEANUP.
  - CLEANUP: line=1 for 1 cycle, then go to IDLE.
  - Illegal state codes go to IDLE with line=1.
- Timing:
  - The line changes on the same edge the state changes.
  - A write at edge t into an empty FIFO with the block IDLE makes the FIFO non-empty at t+1. START begins, with the line low, at edge t+2.
  - Frame length is 10N cycles from the start-bit edge to the stop-bit end.
  - Back-to-back frames from a non-empty FIFO have a 2-cycle inter-frame high gap (CLEANUP + IDLE), so the line is high for N+2 cycles between start bits.
- o_Tx_Active=1 exactly in START, DATA and STOP.
- The 32-bit counter compare is unsigned; no overflow, since N ≤ 2^32-1.

Test Plan:
- Reset then idle, no stimulus for 50 cycles → o_Tx_Serial=1, o_Tx_Empty=1, o_Tx_Active=0, o_Tx_Done never asserted.
- Single frame: load CLKS_PER_BIT=4, write 0xA5 → start 2 cycles after the write. Line, 4 cycles per bit: 0, then data 1,0,1,0,0,1,0,1, then 1. o_Tx_Done pulses once at cycle 40 of the frame. The byte reassembled LSB-first equals 0xA5.
- FIFO full and drop, N=4: write 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles.
  - The first write is popped immediately, so 0x01–0x05 are accepted; o_Tx_Full rises after 0x05 and 0x06 is dropped.
  - Five frames are sent in order; each gap between a stop bit and the next start is N+2=6 high cycles.
- Baud load lockout: start a frame with N=4, assert ld_CLKS_PER_BIT with 8 mid-frame → the frame completes at 4 cycles/bit and CLKS_PER_BIT_s stays 4. Reload 8 while idle → the next frame uses 8 cycles/bit (80 cycles per frame).
- Edge baud: CLKS_PER_BIT_s=0 and =1, write 0xFF → both produce a 10-cycle frame: 0, then eight 1s, then 1, with o_Tx_Done pulsing.
- Reset mid-operation: during DATA bit 3 with 2 bytes queued, pulse rst_n low for 1 cycle → the line goes high immediately and the FIFO is empty. CLKS_PER_BIT_s=0, so the baud value must be reloaded. No o_Tx_Done pulse and no further frame until a new write.
